// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two producer result FIFOs (ALU, LSB) drained round-robin
// onto a single registered CDB broadcast consumed by the RS, ROB and LSB.

module cdb_result_fifo #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              flush,
    input  logic              push,
    input  logic [ROB_W-1:0]  push_dest,
    input  logic [DATA_W-1:0] push_result,
    input  logic              pop,
    output logic              empty,
    output logic              full,
    output logic [ROB_W-1:0]  head_dest,
    output logic [DATA_W-1:0] head_result,
    output logic              drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ROB_W-1:0]  dest_mem   [DEPTH];
    logic [DATA_W-1:0] result_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push_valid;
    logic              accept;

    // A full FIFO still takes a push when its head leaves in the same cycle.
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign push_valid  = push && (push_dest != '0);
    assign accept      = advance && push_valid && (!full || pop);
    assign drop        = advance && push_valid && full && !pop;
    assign head_dest   = dest_mem[rd_ptr];
    assign head_result = result_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (advance) begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            dest_mem[wr_ptr]   <= push_dest;
            result_mem[wr_ptr] <= push_result;
        end
    end

endmodule

module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_rdy,
    input  logic              in_flush,
    input  logic              in_alu_enable,
    input  logic [ROB_W-1:0]  in_alu_dest,
    input  logic [DATA_W-1:0] in_alu_result,
    output logic              out_alu_full,
    input  logic              in_lsb_enable,
    input  logic [ROB_W-1:0]  in_lsb_dest,
    input  logic [DATA_W-1:0] in_lsb_result,
    output logic              out_lsb_full,
    output logic              out_cdb_enable,
    output logic [ROB_W-1:0]  out_cdb_reorder,
    output logic [DATA_W-1:0] out_cdb_result,
    output logic              out_cdb_src,
    output logic              out_drop_err
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSB = 1'b1
    } grant_t;

    grant_t            last_grant;
    grant_t            last_grant_next;
    logic              advance;
    logic              grant_alu;
    logic              grant_lsb;
    logic              alu_empty;
    logic              lsb_empty;
    logic              alu_drop;
    logic              lsb_drop;
    logic [ROB_W-1:0]  alu_head_dest;
    logic [ROB_W-1:0]  lsb_head_dest;
    logic [DATA_W-1:0] alu_head_result;
    logic [DATA_W-1:0] lsb_head_result;

    assign advance = in_rdy && !in_flush;

    cdb_result_fifo #(.DATA_W(DATA_W), .ROB_W(ROB_W), .DEPTH(DEPTH)) alu_fifo (
        .clk         (in_clk),
        .rst_n       (in_rst_n),
        .advance     (advance),
        .flush       (in_flush),
        .push        (in_alu_enable),
        .push_dest   (in_alu_dest),
        .push_result (in_alu_result),
        .pop         (grant_alu),
        .empty       (alu_empty),
        .full        (out_alu_full),
        .head_dest   (alu_head_dest),
        .head_result (alu_head_result),
        .drop        (alu_drop)
    );

    cdb_result_fifo #(.DATA_W(DATA_W), .ROB_W(ROB_W), .DEPTH(DEPTH)) lsb_fifo (
        .clk         (in_clk),
        .rst_n       (in_rst_n),
        .advance     (advance),
        .flush       (in_flush),
        .push        (in_lsb_enable),
        .push_dest   (in_lsb_dest),
        .push_result (in_lsb_result),
        .pop         (grant_lsb),
        .empty       (lsb_empty),
        .full        (out_lsb_full),
        .head_dest   (lsb_head_dest),
        .head_result (lsb_head_result),
        .drop        (lsb_drop)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            last_grant <= GRANT_LSB;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    // Round-robin only matters when both heads compete; the loser of last time wins.
    always_comb begin
        grant_alu       = 1'b0;
        grant_lsb       = 1'b0;
        last_grant_next = last_grant;
        if (in_flush) begin
            last_grant_next = GRANT_LSB;
        end else if (in_rdy) begin
            if (!alu_empty && (lsb_empty || last_grant == GRANT_LSB)) begin
                grant_alu       = 1'b1;
                last_grant_next = GRANT_ALU;
            end else if (!lsb_empty) begin
                grant_lsb       = 1'b1;
                last_grant_next = GRANT_LSB;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_cdb_enable  <= 1'b0;
            out_cdb_reorder <= '0;
            out_cdb_result  <= '0;
            out_cdb_src     <= 1'b0;
            out_drop_err    <= 1'b0;
        end else if (in_flush) begin
            out_cdb_enable <= 1'b0;
        end else if (in_rdy) begin
            out_cdb_enable <= grant_alu || grant_lsb;
            out_drop_err   <= out_drop_err || alu_drop || lsb_drop;
            if (grant_alu) begin
                out_cdb_reorder <= alu_head_dest;
                out_cdb_result  <= alu_head_result;
                out_cdb_src     <= 1'b0;
            end else if (grant_lsb) begin
                out_cdb_reorder <= lsb_head_dest;
                out_cdb_result  <= lsb_head_result;
                out_cdb_src     <= 1'b1;
            end
        end
    end

endmodule
